// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module : imm_gen_pkg
// Brief  : Shared immediate-format encodings and RV opcode constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_SHAMT = 3'd2,
    FMT_S     = 3'd3,
    FMT_B     = 3'd4,
    FMT_U     = 3'd5,
    FMT_J     = 3'd6,
    FMT_CSR   = 3'd7
  } imm_fmt_e;

  // Perf slot for unrecognised opcodes; shares its index with FMT_CSR.
  localparam logic [2:0] FMT_ILL = 3'd7;
  localparam int NUM_FMT = 8;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/imm_gen_decode.sv
// ============================================================================
// Module : imm_gen_decode
// Brief  : Combinational RV instruction classifier and XLEN immediate builder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output imm_fmt_e        o_fmt,
  output logic            o_illegal
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_is_shift;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0] w_shamt, w_shamt_w, w_imm_csr;

  assign w_opc      = i_instr[6:0];
  assign w_f3       = i_instr[14:12];
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  assign w_imm_i   = XLEN'($signed(i_instr[31:20]));
  assign w_imm_s   = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign w_imm_b   = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign w_imm_u   = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign w_imm_j   = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));
  // RV64 shifts carry a 6-bit shamt; the word-sized variants keep 5 bits.
  assign w_shamt   = (XLEN == 64) ? XLEN'(i_instr[25:20]) : XLEN'(i_instr[24:20]);
  assign w_shamt_w = XLEN'(i_instr[24:20]);
  assign w_imm_csr = XLEN'(i_instr[19:15]);

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    case (w_opc)
      OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
        o_fmt = FMT_I;
        o_imm = w_imm_i;
      end
      OPC_OP_IMM: begin
        o_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
        o_imm = w_is_shift ? w_shamt : w_imm_i;
      end
      OPC_OP_IMM_32: begin
        if (XLEN == 64) begin
          o_fmt = w_is_shift ? FMT_SHAMT : FMT_I;
          o_imm = w_is_shift ? w_shamt_w : w_imm_i;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        o_fmt = FMT_S;
        o_imm = w_imm_s;
      end
      OPC_BRANCH: begin
        o_fmt = FMT_B;
        o_imm = w_imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt = FMT_U;
        o_imm = w_imm_u;
      end
      OPC_JAL: begin
        o_fmt = FMT_J;
        o_imm = w_imm_j;
      end
      OPC_SYSTEM: begin
        o_fmt = w_f3[2] ? FMT_CSR : FMT_I;
        o_imm = w_f3[2] ? w_imm_csr : w_imm_i;
      end
      OPC_OP, OPC_OP_32: begin
        o_fmt = FMT_NONE;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_gen_pipe.sv
// ============================================================================
// Module : imm_gen_pipe
// Brief  : Handshaked immediate generator with registered output and skid
//          buffer. Optional per-format perf counters via IMM_GEN_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
`ifdef IMM_GEN_PERF_EN
  ,
  input  logic [2:0]       perf_sel,
  output logic [CNT_W-1:0] perf_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic            illegal;
  } imm_entry_t;

  localparam imm_entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

  imm_entry_t w_dec;
  imm_entry_t r_main, r_skid;
  logic       r_main_valid, r_skid_valid;
  logic       w_in_fire, w_out_fire, w_main_free;

  imm_gen_decode #(.XLEN(XLEN)) u_decode (
    .i_instr   (in_instr),
    .o_imm     (w_dec.imm),
    .o_fmt     (w_dec.fmt),
    .o_illegal (w_dec.illegal)
  );

  // The skid register can only be occupied while main is, so in_ready
  // depends solely on skid occupancy.
  assign w_in_fire   = in_valid & ~r_skid_valid;
  assign w_out_fire  = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= ENTRY_RST;
      r_skid       <= ENTRY_RST;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main       <= w_dec;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_imm     = r_main.imm;
  assign out_fmt     = r_main.fmt;
  assign out_illegal = r_main.illegal;

`ifdef IMM_GEN_PERF_EN
  logic [CNT_W-1:0] r_cnt [NUM_FMT];
  logic [2:0]       w_cnt_idx;

  assign w_cnt_idx = r_main.illegal ? FMT_ILL : r_main.fmt;

  // Counts every taken output, including one taken in a flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FMT; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (w_out_fire && (r_cnt[w_cnt_idx] != {CNT_W{1'b1}})) begin
      r_cnt[w_cnt_idx] <= r_cnt[w_cnt_idx] + 1'b1;
    end
  end

  assign perf_cnt = r_cnt[perf_sel];
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// Module : tb_imm_gen_pipe
// Brief  : Scoreboard bench driving XLEN=32 and XLEN=64 instances in lockstep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        in_ready32, out_valid32, out_ill32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_ill64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
`ifdef IMM_GEN_PERF_EN
  logic [2:0]  perf_sel = '0;
  logic [15:0] perf_cnt32, perf_cnt64;
`endif

  always #10 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_ill32)
`ifdef IMM_GEN_PERF_EN
    , .perf_sel(perf_sel), .perf_cnt(perf_cnt32)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_ill64)
`ifdef IMM_GEN_PERF_EN
    , .perf_sel(perf_sel), .perf_cnt(perf_cnt64)
`endif
  );

  typedef struct packed {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$], q64[$];
  exp_t pend32, pend64;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_rdy = 1'b0;
  int   cnt32_m[8], cnt64_m[8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    exp_t e;
    e.imm = imm;
    e.fmt = fmt;
    e.ill = ill;
    return e;
  endfunction

  function automatic longint sx(input logic [31:0] x, input int bits);
    longint t;
    t = longint'(x) << (64 - bits);
    return t >>> (64 - bits);
  endfunction

  // Reference decoder built from shifts and masks on the whole word.
  function automatic exp_t model(input logic [31:0] ins, input bit is64);
    exp_t        e;
    logic [31:0] f;
    e = '0;
    case (ins[6:0])
      7'h03, 7'h67, 7'h0F: begin e.fmt = 3'd1; e.imm = sx(ins >> 20, 12); end
      7'h13: begin
        if (ins[13:12] == 2'b01) begin
          e.fmt = 3'd2;
          e.imm = is64 ? 64'((ins >> 20) & 63) : 64'((ins >> 20) & 31);
        end else begin
          e.fmt = 3'd1; e.imm = sx(ins >> 20, 12);
        end
      end
      7'h1B: begin
        if (!is64) e.ill = 1'b1;
        else if (ins[13:12] == 2'b01) begin e.fmt = 3'd2; e.imm = 64'((ins >> 20) & 31); end
        else begin e.fmt = 3'd1; e.imm = sx(ins >> 20, 12); end
      end
      7'h23: begin
        f = ((ins >> 25) << 5) | ((ins >> 7) & 31);
        e.fmt = 3'd3; e.imm = sx(f, 12);
      end
      7'h63: begin
        f = (((ins >> 31) & 1) << 12) | (((ins >> 7) & 1) << 11)
          | (((ins >> 25) & 63) << 5) | (((ins >> 8) & 15) << 1);
        e.fmt = 3'd4; e.imm = sx(f, 13);
      end
      7'h37, 7'h17: begin e.fmt = 3'd5; e.imm = sx(ins & 32'hFFFF_F000, 32); end
      7'h6F: begin
        f = (((ins >> 31) & 1) << 20) | (((ins >> 12) & 255) << 12)
          | (((ins >> 20) & 1) << 11) | (((ins >> 21) & 1023) << 1);
        e.fmt = 3'd6; e.imm = sx(f, 21);
      end
      7'h73: begin
        if (ins[14]) begin e.fmt = 3'd7; e.imm = 64'((ins >> 15) & 31); end
        else begin e.fmt = 3'd1; e.imm = sx(ins >> 20, 12); end
      end
      7'h33, 7'h3B: e = '0;
      default: e.ill = 1'b1;
    endcase
    if (!is64) e.imm = e.imm & 64'hFFFF_FFFF;
    return e;
  endfunction

  // Scoreboard monitor: sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid32 && out_ready) begin
        check("dut32 out_has_pending", 64'(q32.size() != 0), 64'd1);
        if (q32.size() != 0) begin
          e = q32.pop_front();
          check("dut32 imm", 64'(out_imm32), e.imm);
          check("dut32 fmt", 64'(out_fmt32), 64'(e.fmt));
          check("dut32 illegal", 64'(out_ill32), 64'(e.ill));
          cnt32_m[e.ill ? 7 : int'(e.fmt)]++;
        end
      end
      if (out_valid64 && out_ready) begin
        check("dut64 out_has_pending", 64'(q64.size() != 0), 64'd1);
        if (q64.size() != 0) begin
          e = q64.pop_front();
          check("dut64 imm", out_imm64, e.imm);
          check("dut64 fmt", 64'(out_fmt64), 64'(e.fmt));
          check("dut64 illegal", 64'(out_ill64), 64'(e.ill));
          cnt64_m[e.ill ? 7 : int'(e.fmt)]++;
        end
      end
      if (!flush && in_valid && in_ready32) q32.push_back(pend32);
      if (!flush && in_valid && in_ready64) q64.push_back(pend64);
      if (flush) begin
        q32.delete();
        q64.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic present(input logic [31:0] ins, input exp_t e32, input exp_t e64);
    in_valid = 1'b1;
    in_instr = ins;
    pend32   = e32;
    pend64   = e64;
  endtask

  task automatic send(input logic [31:0] ins, input exp_t e32, input exp_t e64);
    bit acc;
    int n;
    present(ins, e32, e64);
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready64;
      tick();
      n++;
    end
    if (!acc) check("send accept timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] ins);
    send(ins, model(ins, 1'b0), model(ins, 1'b1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain queues empty", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " in_ready32"}, 64'(in_ready32), 64'd1);
    check({tag, " out_valid32"}, 64'(out_valid32), 64'd0);
    check({tag, " in_ready64"}, 64'(in_ready64), 64'd1);
    check({tag, " out_valid64"}, 64'(out_valid64), 64'd0);
  endtask

`ifdef IMM_GEN_PERF_EN
  task automatic perf_check(input string tag);
    for (int s = 0; s < 8; s++) begin
      perf_sel = 3'(s);
      #1;
      check({tag, " perf32"}, 64'(perf_cnt32), 64'(cnt32_m[s]));
      check({tag, " perf64"}, 64'(perf_cnt64), 64'(cnt64_m[s]));
    end
  endtask
`endif

  logic [6:0] opcs [16] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h13, 7'h1B, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h73, 7'h73, 7'h33, 7'h3B, 7'h7F};

  initial begin
    logic [31:0] ins;
    int          k;
    for (int i = 0; i < 8; i++) begin cnt32_m[i] = 0; cnt64_m[i] = 0; end

    // Reset and idle
    repeat (2) @(negedge clk);
    check("rst out_imm64", out_imm64, 64'd0);
    check("rst out_fmt64", 64'(out_fmt64), 64'd0);
    check("rst out_ill64", 64'(out_ill64), 64'd0);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle("idle");
      check("idle out_imm32", 64'(out_imm32), 64'd0);
      check("idle out_imm64", out_imm64, 64'd0);
    end
    tick();

    // First-transfer latency
    out_ready = 1'b1;
    send(32'hFFF0_0093, mk(64'hFFFF_FFFF, 3'd1, 1'b0), mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0));
    @(negedge clk);
    check("latency out_valid32", 64'(out_valid32), 64'd1);
    check("latency addi imm32", 64'(out_imm32), 64'hFFFF_FFFF);
    check("latency addi fmt32", 64'(out_fmt32), 64'd1);
    tick();

    // Directed formats, back to back
    send(32'hFE00_0EE3, mk(64'hFFFF_FFFC, 3'd4, 0), mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 0));
    send(32'h8000_00EF, mk(64'hFFF0_0000, 3'd6, 0), mk(64'hFFFF_FFFF_FFF0_0000, 3'd6, 0));
    send(32'h8000_00B7, mk(64'h8000_0000, 3'd5, 0), mk(64'hFFFF_FFFF_8000_0000, 3'd5, 0));
    send(32'h03F0_9093, mk(64'd31, 3'd2, 0), mk(64'd63, 3'd2, 0));
    send(32'h3401_D073, mk(64'd3, 3'd7, 0), mk(64'd3, 3'd7, 0));
    send(32'h0000_007F, mk(64'd0, 3'd0, 1), mk(64'd0, 3'd0, 1));
    send(32'hFE11_2E23, mk(64'hFFFF_FFFC, 3'd3, 0), mk(64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 0));
    send(32'h0020_81B3, mk(64'd0, 3'd0, 0), mk(64'd0, 3'd0, 0));
    send(32'hFFF0_809B, mk(64'd0, 3'd0, 1), mk(64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 0));
    send(32'h01F0_909B, mk(64'd0, 3'd0, 1), mk(64'd31, 3'd2, 0));
    send(32'h8000_2083, mk(64'hFFFF_F800, 3'd1, 0), mk(64'hFFFF_FFFF_FFFF_F800, 3'd1, 0));
    send(32'h3401_1073, mk(64'h340, 3'd1, 0), mk(64'h340, 3'd1, 0));
    send(32'h4050_D093, mk(64'd5, 3'd2, 0), mk(64'd5, 3'd2, 0));
    send(32'h1234_5097, mk(64'h1234_5000, 3'd5, 0), mk(64'h1234_5000, 3'd5, 0));
    send(32'h0020_8463, mk(64'd8, 3'd4, 0), mk(64'd8, 3'd4, 0));
    send(32'h0080_006F, mk(64'd8, 3'd6, 0), mk(64'd8, 3'd6, 0));
    drain();

    // Stall: main and skid fill, third word waits
    out_ready = 1'b0;
    send_m(32'h0010_0093);
    send_m(32'h0020_0113);
    present(32'h0030_0193, model(32'h0030_0193, 0), model(32'h0030_0193, 1));
    repeat (4) begin
      @(negedge clk);
      check("stall in_ready32", 64'(in_ready32), 64'd0);
      check("stall in_ready64", 64'(in_ready64), 64'd0);
      check("stall out_valid64", 64'(out_valid64), 64'd1);
      check("stall held imm64", out_imm64, 64'd1);
      tick();
    end
    out_ready = 1'b1;
    send_m(32'h0030_0193);
    drain();

    // Flush with both registers full and a word offered
    out_ready = 1'b0;
    send_m(32'h0040_0213);
    send_m(32'h0050_0293);
    present(32'h0060_0313, model(32'h0060_0313, 0), model(32'h0060_0313, 1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("after flush");
`ifdef IMM_GEN_PERF_EN
    perf_check("flush");
`endif
    tick();

    // Flush coinciding with an output handshake and an offered input
    out_ready = 1'b1;
    send_m(32'h0070_0393);
    present(32'h0080_0413, model(32'h0080_0413, 0), model(32'h0080_0413, 1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check_idle("flush+handshake");
    tick();

    // Asynchronous reset in the middle of a transfer
    out_ready = 1'b0;
    send_m(32'hFFF0_0093);
    send_m(32'h8000_00B7);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    check("async reset imm64", out_imm64, 64'd0);
    check("async reset fmt64", 64'(out_fmt64), 64'd0);
    q32.delete();
    q64.delete();
    for (int i = 0; i < 8; i++) begin cnt32_m[i] = 0; cnt64_m[i] = 0; end
    tick();
    rst_n = 1'b1;
    tick();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      ins = $urandom;
      k   = $urandom_range(0, 15);
      if (k != 15) ins[6:0] = opcs[k];
      send_m(ins);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    check_idle("end");
`ifdef IMM_GEN_PERF_EN
    perf_check("end");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
